// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Holds the FSM encoding, default sizing and the BCD digit-valid helper.
package bcd_to_bin_seq_pkg;

  localparam int unsigned DEF_NDIGITS = 3;
  localparam int unsigned DEF_BIN_W   = 10;
  localparam int unsigned DIGIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A BCD digit is legal only in the range 0..9.
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction step of the reverse double-dabble: a digit of 8 or
// more after the right shift gets 3 taken off, with no borrow to its neighbours.
module bcd_digit_corr
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corr_c
);

  assign corr_c = (digit >= DIGIT_W'(8)) ? digit - DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: loads a packed BCD word on start and
// returns the binary value after BIN_W shift/correct cycles.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int unsigned NDIGITS = DEF_NDIGITS,
  parameter int unsigned BIN_W   = DEF_BIN_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] bcd_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [BIN_W-1:0]           bin_out
);

  localparam int unsigned BCD_W  = DIGIT_W * NDIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WORK_W-1:0]   shifted_c, next_work_c;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                in_err_c;

  // Any non-decimal digit in the incoming operand flags the whole conversion.
  always_comb begin
    in_err_c = 1'b0;
    for (int unsigned g = 0; g < NDIGITS; g++) begin
      if (!digit_valid(bcd_in[g*DIGIT_W +: DIGIT_W])) in_err_c = 1'b1;
    end
  end

  assign shifted_c                = work_q >> 1;
  assign next_work_c[BIN_W-1:0]   = shifted_c[BIN_W-1:0];

  for (genvar g = 0; g < NDIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .digit  (shifted_c[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .corr_c (next_work_c[BIN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          cnt_d   = '0;
          err_d   = in_err_c;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = next_work_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; results latch on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy    <= (state_d == ST_SHIFT);
      done    <= (state_d == ST_DONE);
      if (state_q == ST_SHIFT && state_d == ST_DONE) begin
        bin_out <= err_q ? '0 : next_work_c[BIN_W-1:0];
        err     <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: directed cases, exhaustive decimal
// sweep and random operands against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

  localparam int unsigned NDIGITS = 3;
  localparam int unsigned BIN_W   = 10;
  localparam int unsigned BCD_W   = 4 * NDIGITS;
  localparam int unsigned LAT     = BIN_W + 1;
  localparam int unsigned BOUND   = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [BCD_W-1:0] bcd_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] bin_out;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_to_bin_seq #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: read the operand as a decimal number; any nibble > 9 is an error.
  function automatic void ref_conv(input logic [BCD_W-1:0] b, output int val, output bit e);
    int dig;
    e   = 1'b0;
    val = 0;
    for (int d = NDIGITS - 1; d >= 0; d--) begin
      dig = int'((b >> (4 * d)) & 4'hF);
      if (dig > 9) e = 1'b1;
      val = val * 10 + dig;
    end
    if (e) val = 0;
  endfunction

  // Wait for done from the negedge after the start edge; returns cycle count.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!done && lat < BOUND) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv(input logic [BCD_W-1:0] b, input string tag);
    int val, lat, busy_n;
    bit e;
    ref_conv(b, val, e);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    @(negedge clk);
    start  = 1'b0;
    wait_done(lat, busy_n);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_busy"}, 32'(busy_n), 32'(BIN_W));
    check({tag, "_bin"}, 32'(bin_out), 32'(val));
    check({tag, "_err"}, 32'(err), 32'(e));
    if (!e) check({tag, "_resid"}, 32'(dut.work_q[BCD_W+BIN_W-1:BIN_W]), 32'd0);
  endtask

  initial begin
    int lat, busy_n;
    logic [BCD_W-1:0] r;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_bin",  32'(bin_out), 32'd0);
    rst = 1'b0;

    // Directed values
    conv(12'h999, "t1_999");
    conv(12'h000, "t2_000");
    conv(12'h255, "t2_255");
    conv(12'h001, "t2_001");
    conv(12'h1A3, "t3_1a3");
    conv(12'h123, "t3_123");

    // Exhaustive decimal sweep
    for (int v = 0; v < 1000; v++) begin
      r = BCD_W'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
      conv(r, "sweep");
    end

    // Random operands including non-decimal nibbles
    for (int k = 0; k < 200; k++) begin
      r = BCD_W'($urandom_range(0, 4095));
      conv(r, "rand");
    end

    // Start held throughout a conversion, then accepted back-to-back in DONE
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h500;
    @(negedge clk);
    bcd_in = 12'h321;
    wait_done(lat, busy_n);
    check("t4_lat1", 32'(lat), 32'(LAT));
    check("t4_bin1", 32'(bin_out), 32'd500);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    check("t4_lat2", 32'(lat), 32'(LAT));
    check("t4_bin2", 32'(bin_out), 32'd321);
    check("t4_err2", 32'(err), 32'd0);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h777;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err",  32'(err),  32'd0);
    check("t5_bin",  32'(bin_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("t5_nodone", 32'(done), 32'd0);
    end
    conv(12'h042, "t5_042");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
